seg7_scan_decoder: RTL

// - Reverse path of the seven-segment encoder: watches a multiplexed, active-low segment
//   bus (HEX[7:0] plus one-hot digit select) and recovers the decimal digit on each position.
// - Used as an on-board display monitor/self-check and as the bench-side reader in lab
//   top-levels.
// - Debounces each pattern, decodes it, stores one value per digit and pulses an update strobe.

---
 rtl/seg7_scan_decoder_pkg.sv | 31 +++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/seg7_scan_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder_pkg : shared segment patterns, numeric codes, FSM states
// Rev 1.0
// ============================================================================
package seg7_scan_decoder_pkg;

    // Active-low g..a patterns, shared with the encoder direction
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] NUM_BLANK   = 8'd88;
    localparam logic [7:0] NUM_INVALID = 8'd99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } scan_state_t;

endpackage : seg7_scan_decoder_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// seg7_pattern_decode : active-low 7-segment pattern -> numeric code + known flag
// Rev 1.0
// ============================================================================
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [7:0] num,
    output logic       known
);

    always_comb begin
        num   = NUM_INVALID;
        known = 1'b1;
        case (seg)
            SEG_0:     num = 8'd0;
            SEG_1:     num = 8'd1;
            SEG_2:     num = 8'd2;
            SEG_3:     num = 8'd3;
            SEG_4:     num = 8'd4;
            SEG_5:     num = 8'd5;
            SEG_6:     num = 8'd6;
            SEG_7:     num = 8'd7;
            SEG_8:     num = 8'd8;
            SEG_9:     num = 8'd9;
            SEG_BLANK: num = NUM_BLANK;
            default: begin
                num   = NUM_INVALID;
                known = 1'b0;
            end
        endcase
    end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder : debounces a multiplexed active-low 7-segment bus and
//                     recovers one decoded value plus decimal point per digit
// Rev 1.0
// ============================================================================
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int N_DIGITS      = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [7:0]            HEX,
    input  logic [N_DIGITS-1:0]   DIG_SEL,
    input  logic                  ERR_CLR,
    output logic [8*N_DIGITS-1:0] NUM_OUT,
    output logic [N_DIGITS-1:0]   DP_OUT,
    output logic                  UPD,
    output logic [2:0]            UPD_IDX,
    output logic                  ERR_SEG,
    output logic                  ERR_SEL
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = N_DIGITS + 8;
    localparam logic [SMP_W-1:0] SAMPLE_RST = {{N_DIGITS{1'b0}}, 8'hFF};
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);

    logic [SMP_W-1:0]             sync1, sync2, prev;
    logic [CNT_W-1:0]             cnt, cnt_next;
    scan_state_t                  state;
    logic [N_DIGITS-1:0][7:0]     slots;
    logic [N_DIGITS-1:0]          dp_q;

    logic [N_DIGITS-1:0] sel;
    logic [7:0]          hex_s;
    logic                sel_multi, one_hot, changed, commit, differs;
    logic [2:0]          slot_idx;
    logic [7:0]          dec_num;
    logic                dec_known;
    logic                dp_new;

    assign sel       = sync2[SMP_W-1:8];
    assign hex_s     = sync2[7:0];
    assign sel_multi = (sel & (sel - N_DIGITS'(1))) != '0;
    assign one_hot   = (|sel) && !sel_multi;
    assign changed   = (sync2 != prev);
    assign dp_new    = ~hex_s[7];

    always_comb begin
        cnt_next = cnt;
        if (changed || !one_hot) begin
            cnt_next = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Commit fires exactly once per stable run, on the edge the count saturates
    assign commit = (state == ST_TRACK) && one_hot && !changed && (cnt_next == CNT_MAX);

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel[i]) begin
                slot_idx = 3'(i);
            end
        end
    end

    seg7_pattern_decode u_decode (
        .seg   (hex_s[6:0]),
        .num   (dec_num),
        .known (dec_known)
    );

    assign differs = (slots[slot_idx] != dec_num) || (dp_q[slot_idx] != dp_new);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1   <= SAMPLE_RST;
            sync2   <= SAMPLE_RST;
            prev    <= SAMPLE_RST;
            cnt     <= '0;
            state   <= ST_IDLE;
            slots   <= {N_DIGITS{NUM_BLANK}};
            dp_q    <= '0;
            UPD     <= 1'b0;
            UPD_IDX <= '0;
            ERR_SEG <= 1'b0;
            ERR_SEL <= 1'b0;
        end else begin
            sync1 <= {DIG_SEL, HEX};
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_next;
            UPD   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (one_hot) state <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (!one_hot)    state <= ST_IDLE;
                    else if (commit) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (changed) state <= one_hot ? ST_TRACK : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (commit && differs) begin
                slots[slot_idx] <= dec_num;
                dp_q[slot_idx]  <= dp_new;
                UPD             <= 1'b1;
                UPD_IDX         <= slot_idx;
            end

            // A new error in the same cycle as ERR_CLR keeps the flag set
            ERR_SEG <= (commit && !dec_known) || (ERR_SEG && !ERR_CLR);
            ERR_SEL <= sel_multi || (ERR_SEL && !ERR_CLR);
        end
    end

    assign NUM_OUT = slots;
    assign DP_OUT  = dp_q;

endmodule : seg7_scan_decoder
`default_nettype wire
